// File: rtl/clock_ctrl_if.sv
// Control and status signals exchanged between the board-level logic and the
// CPU clock controller. The controller itself is the slave side.
interface clock_ctrl_if #(
   parameter int CNT_W = 24
);
   logic [CNT_W-1:0] divider;
   logic             mode;
   logic             step_btn;
   logic             halt;
   logic             slowClk;
   logic             clkRise;
   logic             clkFall;
   logic             halted;

   modport master (
      output divider, mode, step_btn, halt,
      input  slowClk, clkRise, clkFall, halted
   );

   modport slave (
      input  divider, mode, step_btn, halt,
      output slowClk, clkRise, clkFall, halted
   );
endinterface

// File: rtl/clock_ctrl.sv
// CPU clock controller: derives slowClk from fastClk with a programmable
// half-period. It runs free in auto mode, or advances one cycle per debounced
// pushbutton press in manual mode. halt parks the clock in its low phase.
module clock_ctrl #(
   parameter int CNT_W      = 24,
   parameter int DEB_CYCLES = 12000,
   parameter int DEB_W      = 16
) (
   input  logic         fastClk,
   input  logic         rst_n,
   clock_ctrl_if.slave  bus
);

   typedef enum logic {
      LOW  = 1'b0,
      HIGH = 1'b1
   } clkState_t;

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic             btnMeta;
   logic             btnS;
   logic             btnD;
   logic             btnDQ;
   logic [DEB_W-1:0] dCnt;
   logic             stepReq;

   clkState_t        state;
   clkState_t        stateNext;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNext;
   logic [CNT_W-1:0] cntInc;
   logic             modeQ;
   logic             slowReg;
   logic             riseReg;
   logic             fallReg;

   // Two-flop synchroniser bringing the raw pushbutton into the fastClk domain.
   always_ff @(posedge fastClk or negedge rst_n) begin
      // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         btnMeta <= 1'b0;
         btnS    <= 1'b0;
      end else begin
         btnMeta <= bus.step_btn;
         btnS    <= btnMeta;
      end
   end

   // Debouncer: accept a new level only after DEB_CYCLES consecutive differing samples.
   always_ff @(posedge fastClk or negedge rst_n) begin
      if (!rst_n) begin
         btnD  <= 1'b0;
         btnDQ <= 1'b0;
         dCnt  <= '0;
      end else begin
         btnDQ <= btnD;
         if (btnS == btnD) begin
            dCnt <= '0;
         end else if (dCnt == DEB_LAST) begin
            btnD <= btnS;
            dCnt <= '0;
         end else begin
            dCnt <= dCnt + DEB_W'(1);
         end
      end
   end

   // A press is the single cycle in which the debounced level rises.
   assign stepReq = btnD & ~btnDQ;

   // Phase counter saturates instead of wrapping, so a huge divider never aliases.
   assign cntInc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   // Next-state and phase-counter logic for the two-phase clock FSM.
   always_comb begin
      // NOTE: defaults are assigned first so every path drives both outputs and no latch is inferred.
      stateNext = state;
      cntNext   = cnt;
      unique case (state)
         LOW: begin
            if (bus.halt) begin
               cntNext = '0;
            end else if (bus.mode != modeQ) begin
               // A mode switch restarts the low phase from a clean count.
               cntNext = '0;
            end else if (!bus.mode) begin
               if (cnt >= bus.divider) begin
                  stateNext = HIGH;
                  cntNext   = '0;
               end else begin
                  cntNext = cntInc;
               end
            end else begin
               cntNext = '0;
               if (stepReq) begin
                  stateNext = HIGH;
               end
            end
         end
         HIGH: begin
            // The high phase always runs to completion; halt and mode are ignored here.
            if (cnt >= bus.divider) begin
               stateNext = LOW;
               cntNext   = '0;
            end else begin
               cntNext = cntInc;
            end
         end
      endcase
   end

   // State, counter and registered clock outputs with their edge strobes.
   always_ff @(posedge fastClk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= LOW;
         cnt     <= '0;
         modeQ   <= 1'b0;
         slowReg <= 1'b0;
         riseReg <= 1'b0;
         fallReg <= 1'b0;
      end else begin
         state   <= stateNext;
         cnt     <= cntNext;
         modeQ   <= bus.mode;
         slowReg <= (stateNext == HIGH);
         riseReg <= (state == LOW)  && (stateNext == HIGH);
         fallReg <= (state == HIGH) && (stateNext == LOW);
      end
   end

   assign bus.slowClk = slowReg;
   assign bus.clkRise = riseReg;
   assign bus.clkFall = fallReg;
   assign bus.halted  = (state == LOW) & bus.halt;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl. Stimulus tasks compute, from the timing
// rules, the fastClk edge at which each slowClk rise/fall must happen and push
// those events into a queue; a monitor on the falling edge pops them and checks
// slowClk, the edge strobes and halted every cycle.
module tb_clock_ctrl;

   localparam int  CNT_W = 24;
   localparam int  DEB   = 4;
   localparam int  DEB_W = 4;
   localparam time HALF  = 5;

   typedef struct {
      int unsigned cyc;
      bit          rise;
   } edgeEv_t;

   logic fastClk = 1'b0;
   logic rst_n   = 1'b0;

   clock_ctrl_if #(.CNT_W(CNT_W)) bus ();

   clock_ctrl #(
      .CNT_W      (CNT_W),
      .DEB_CYCLES (DEB),
      .DEB_W      (DEB_W)
   ) dut (
      .fastClk (fastClk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #HALF fastClk = ~fastClk;

   int unsigned cyc = 0;
   always @(posedge fastClk) cyc <= cyc + 1;

   edgeEv_t expQ[$];
   bit      pat[$];
   bit      expLevel = 1'b0;
   bit      randBtn  = 1'b0;
   int      checks   = 0;
   int      failures = 0;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pushEv(input int unsigned c, input bit r);
      edgeEv_t ev;
      ev.cyc  = c;
      ev.rise = r;
      expQ.push_back(ev);
   endtask

   // Monitor: retire events due at this edge, then compare the whole output set.
   always @(negedge fastClk) begin
      edgeEv_t ev;
      bit      expRise;
      bit      expFall;
      expRise = 1'b0;
      expFall = 1'b0;
      while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
         ev = expQ.pop_front();
         check(ev.cyc == cyc, "event_time", int'(cyc), int'(ev.cyc));
         if (ev.rise) begin
            expRise  = 1'b1;
            expLevel = 1'b1;
         end else begin
            expFall  = 1'b1;
            expLevel = 1'b0;
         end
      end
      if (!rst_n) expLevel = 1'b0;
      check(bus.slowClk === expLevel, "slowClk", int'(bus.slowClk), int'(expLevel));
      check(bus.clkRise === expRise, "clkRise", int'(bus.clkRise), int'(expRise));
      check(bus.clkFall === expFall, "clkFall", int'(bus.clkFall), int'(expFall));
      check(bus.halted === (bus.halt && !expLevel), "halted", int'(bus.halted),
            int'(bus.halt && !expLevel));
   end

   // Advance to just after edge t, optionally rattling the button (ignored in auto mode).
   task automatic tickTo(input int unsigned t);
      while (cyc < t) begin
         @(posedge fastClk);
         #1;
         if (randBtn) bus.step_btn = 1'($urandom_range(0, 1));
      end
   endtask

   // Asynchronous reset between edges; returns the last edge before the first active one.
   task automatic doReset(input bit m, input int unsigned d, output int unsigned k);
      @(negedge fastClk);
      #1;
      rst_n = 1'b0;
      #1;
      check(bus.slowClk === 1'b0, "rst_slowClk", int'(bus.slowClk), 0);
      check(bus.clkRise === 1'b0, "rst_clkRise", int'(bus.clkRise), 0);
      check(bus.clkFall === 1'b0, "rst_clkFall", int'(bus.clkFall), 0);
      check(expQ.size() == 0, "events_drained", expQ.size(), 0);
      randBtn      = 1'b0;
      bus.halt     = 1'b0;
      bus.step_btn = 1'b0;
      bus.mode     = m;
      bus.divider  = CNT_W'(d);
      repeat (2) @(posedge fastClk);
      #1;
      rst_n = 1'b1;
      k = cyc;
   endtask

   // Free-running clock: rises every 2(d+1) edges starting d+1 edges after release.
   task automatic runAuto(input int unsigned d, input int unsigned len, input bit noise);
      int unsigned k;
      doReset(1'b0, d, k);
      for (int unsigned r = k + d + 1; r <= k + len; r += 2 * (d + 1)) begin
         pushEv(r, 1'b1);
         if (r + d + 1 <= k + len) pushEv(r + d + 1, 1'b0);
      end
      randBtn = noise;
      tickTo(k + len);
      randBtn = 1'b0;
   endtask

   // halt raised two edges into a high phase: the phase completes, then the clock parks.
   task automatic runHaltHigh(input int unsigned d, input int unsigned hold);
      int unsigned k, r, x;
      doReset(1'b0, d, k);
      r = k + d + 1;
      pushEv(r, 1'b1);
      pushEv(r + d + 1, 1'b0);
      tickTo(r + 2);
      bus.halt = 1'b1;
      x = r + d + 1 + hold;
      tickTo(x);
      bus.halt = 1'b0;
      pushEv(x + d + 1, 1'b1);
      pushEv(x + 2 * d + 2, 1'b0);
      tickTo(x + 2 * d + 2);
   endtask

   // halt raised j edges into a low phase freezes it; release restarts the full low phase.
   task automatic runHaltLow(input int unsigned d, input int unsigned j, input int unsigned hold);
      int unsigned k, f, x;
      doReset(1'b0, d, k);
      f = k + 2 * d + 2;
      pushEv(k + d + 1, 1'b1);
      pushEv(f, 1'b0);
      tickTo(f + j);
      bus.halt = 1'b1;
      x = f + j + hold;
      tickTo(x);
      bus.halt = 1'b0;
      pushEv(x + d + 1, 1'b1);
      pushEv(x + 2 * d + 2, 1'b0);
      tickTo(x + 2 * d + 2);
   endtask

   // Divider lowered to d1 <= m while m edges into a high phase: fall on the next edge.
   task automatic runShrink(input int unsigned d0, input int unsigned m, input int unsigned d1);
      int unsigned k, r, f;
      doReset(1'b0, d0, k);
      r = k + d0 + 1;
      pushEv(r, 1'b1);
      tickTo(r + m);
      bus.divider = CNT_W'(d1);
      f = r + m + 1;
      pushEv(f, 1'b0);
      pushEv(f + d1 + 1, 1'b1);
      pushEv(f + 2 * d1 + 2, 1'b0);
      tickTo(f + 2 * d1 + 2);
   endtask

   task automatic addRun(input bit v, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) pat.push_back(v);
   endtask

   // Manual mode: drive pat as the raw button, one sample per edge. A level counts
   // once it has been seen DEB times in a row (two edges of synchroniser delay);
   // an accepted press steps the clock one edge later if the clock is idle low.
   task automatic runManual(input int unsigned d, input bit haltOn);
      int unsigned k, k0, e, a, busy, run;
      bit          deb;
      doReset(1'b1, d, k);
      bus.halt = haltOn;
      addRun(1'b0, 2 * DEB + d + 6);
      k0   = k + 1;
      deb  = 1'b0;
      run  = 0;
      busy = 0;
      for (int unsigned i = 0; i < pat.size(); i++) begin
         e = k0 + 1 + i;
         if (pat[i] != deb) begin
            run++;
            if (run == DEB) begin
               deb = pat[i];
               run = 0;
               a   = e + 2;
               if (deb && !haltOn && busy <= a) begin
                  pushEv(a + 1, 1'b1);
                  pushEv(a + d + 2, 1'b0);
                  busy = a + d + 2;
               end
            end
         end else begin
            run = 0;
         end
      end
      for (int unsigned i = 0; i < pat.size(); i++) begin
         tickTo(k0 + i);
         bus.step_btn = pat[i];
      end
      tickTo(k0 + pat.size());
      bus.halt = 1'b0;
      pat.delete();
   endtask

   initial begin
      int unsigned d;
      bus.divider  = '0;
      bus.mode     = 1'b0;
      bus.step_btn = 1'b0;
      bus.halt     = 1'b0;
      #2;
      check(bus.slowClk === 1'b0, "init_slowClk", int'(bus.slowClk), 0);
      check(bus.halted === 1'b0, "init_halted_lo", int'(bus.halted), 0);
      bus.halt = 1'b1;
      #1;
      check(bus.halted === 1'b1, "init_halted_hi", int'(bus.halted), 1);
      bus.halt = 1'b0;

      runAuto(3, 40, 1'b0);
      runAuto(0, 20, 1'b0);
      runAuto(3, 21, 1'b0);
      for (int i = 0; i < 6; i++) begin
         d = $urandom_range(0, 9);
         runAuto(d, (d + 1) + 2 * (d + 1) * $urandom_range(1, 3) + $urandom_range(0, d), 1'b1);
      end

      runHaltHigh(5, 4);
      for (int i = 0; i < 3; i++) runHaltHigh($urandom_range(2, 8), $urandom_range(1, 10));
      for (int i = 0; i < 3; i++) begin
         d = $urandom_range(0, 7);
         runHaltLow(d, $urandom_range(0, d), $urandom_range(1, 10));
      end

      runShrink(20, 10, 4);
      for (int i = 0; i < 2; i++) begin
         int unsigned d0, m;
         d0 = $urandom_range(10, 30);
         m  = $urandom_range(5, d0 - 1);
         runShrink(d0, m, $urandom_range(0, m));
      end

      addRun(1'b1, 12);
      runManual(2, 1'b0);
      addRun(1'b1, 3); addRun(1'b0, 3); addRun(1'b1, 3); addRun(1'b0, 3); addRun(1'b1, 10);
      runManual(2, 1'b0);
      addRun(1'b1, 3);
      runManual(2, 1'b0);
      addRun(1'b1, 12);
      runManual(2, 1'b1);
      for (int i = 0; i < 6; i++) begin
         for (int r = 0; r < 10; r++) addRun(1'((r + 1) % 2), $urandom_range(1, 9));
         runManual($urandom_range(0, 12), 1'b0);
      end

      @(negedge fastClk);
      #1;
      check(expQ.size() == 0, "final_drain", expQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
